// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: steps each instruction through fetch and execute machine cycles of one-hot beats,
// stretching beats on pending bus transfers and locking into an error state on bus-wait timeout.
module multicycle_sequencer #(
    parameter int MAX_PHASES = 4,
    parameter int CNT_W      = 2,
    parameter int IF_PHASES  = 2,
    parameter int TO_W       = 8,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  halt,
    input  logic [CNT_W-1:0]      ex_len,
    input  logic                  bus_req,
    input  logic                  bus_done,
    output logic [MAX_PHASES-1:0] phase,
    output logic                  mif,
    output logic                  mex,
    output logic                  ir_en,
    output logic                  insn_done,
    output logic                  stall,
    output logic                  busy,
    output logic                  bus_timeout
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERROR} state_t;
    state_t                  r_state, w_next;
    logic [CNT_W-1:0]        r_beat, r_len, w_nbeat, w_len;
    logic [TO_W-1:0]         r_wait;
    logic [MAX_PHASES-1:0]   r_phase;
    logic                    r_mif, r_mex, r_busy, r_to;
    logic                    w_busy, w_stall, w_adv, w_last, w_go;
    // In EXEC T1 the decoder output is live; later beats use the length latched when T1 completed.
    always_comb begin
        w_busy  = r_state == FETCH || r_state == EXEC;
        w_stall = w_busy && bus_req && !bus_done;
        w_adv   = w_busy && !w_stall;
        w_len   = r_state == FETCH ? CNT_W'(IF_PHASES - 1) : r_beat == '0 ? ex_len : r_len;
        w_last  = r_beat == w_len;
        w_go    = run && !halt;
        w_next  = r_state;
        w_nbeat = r_beat;
        if (r_state == IDLE && w_go) begin
            w_next  = FETCH;
            w_nbeat = '0;
        end else if (w_adv) begin
            w_next  = !w_last ? r_state : r_state == FETCH ? EXEC : w_go ? FETCH : IDLE;
            w_nbeat = w_last ? '0 : r_beat + 1'b1;
        end else if (w_stall && r_wait == TO_W'(WAIT_LIMIT - 1)) begin
            w_next = ERROR;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_len   <= '0;
            r_wait  <= '0;
            r_phase <= '0;
            r_mif   <= 1'b0;
            r_mex   <= 1'b0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_beat  <= w_nbeat;
            r_wait  <= w_stall ? r_wait + 1'b1 : '0;
            if (r_state == EXEC && r_beat == '0 && w_adv)
                r_len <= ex_len;
            r_phase <= (w_next == FETCH || w_next == EXEC) ? MAX_PHASES'(1) << w_nbeat : '0;
            r_mif   <= w_next == FETCH;
            r_mex   <= w_next == EXEC;
            r_busy  <= w_next == FETCH || w_next == EXEC;
            r_to    <= w_next == ERROR;
        end
    end
    assign phase       = r_phase;
    assign mif         = r_mif;
    assign mex         = r_mex;
    assign busy        = r_busy;
    assign bus_timeout = r_to;
    assign stall       = w_stall;
    assign ir_en       = r_state == FETCH && w_adv && w_last;
    assign insn_done   = r_state == EXEC && w_adv && w_last;
endmodule
